// File: rtl/ysyx_24100006_gpr_sb.sv
// General-purpose register file with two write ports, NUM_RD read ports and a busy scoreboard.
// Define YSYX_24100006_GPR_BYPASS_EN to forward same-cycle writes onto the read ports.
module ysyx_24100006_gpr_sb #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RD     = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           wen0,
  input  logic [ADDR_WIDTH-1:0]          waddr0,
  input  logic [DATA_WIDTH-1:0]          wdata0,
  input  logic                           wen1,
  input  logic [ADDR_WIDTH-1:0]          waddr1,
  input  logic [DATA_WIDTH-1:0]          wdata1,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]   raddr,
  output logic [NUM_RD*DATA_WIDTH-1:0]   rdata,
  output logic [NUM_RD-1:0]              rbusy,
  input  logic                           issue_valid,
  input  logic [ADDR_WIDTH-1:0]          issue_rd,
  output logic                           issue_ready
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] rf_q [DEPTH];
  logic [DATA_WIDTH-1:0] rf_d [DEPTH];
  logic [DEPTH-1:0]      busy_q;
  logic [DEPTH-1:0]      busy_d;
  logic                  wr0Act;
  logic                  wr1Act;
  logic                  issueAcc;

  assign wr0Act      = wen0 && (waddr0 != '0);
  assign wr1Act      = wen1 && (waddr1 != '0);
  assign issue_ready = (issue_rd == '0) || !busy_q[issue_rd];
  assign issueAcc    = issue_valid && issue_ready && (issue_rd != '0);

  // Port 1 is applied last so it wins a same-index collision; a new issue wins over a clear.
  always_comb begin
    rf_d   = rf_q;
    busy_d = busy_q;
    if (wr0Act) begin
      rf_d[waddr0]   = wdata0;
      busy_d[waddr0] = 1'b0;
    end
    if (wr1Act) begin
      rf_d[waddr1]   = wdata1;
      busy_d[waddr1] = 1'b0;
    end
    if (issueAcc) begin
      busy_d[issue_rd] = 1'b1;
    end
    rf_d[0]   = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rf_q   <= '{default: '0};
      busy_q <= '0;
    end else begin
      rf_q   <= rf_d;
      busy_q <= busy_d;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic [DATA_WIDTH-1:0] rd;
    logic                  rb;

    assign ra = raddr[k*ADDR_WIDTH +: ADDR_WIDTH];

`ifdef YSYX_24100006_GPR_BYPASS_EN
    always_comb begin
      rd = rf_q[ra];
      rb = busy_q[ra];
      if (!reset && (ra != '0)) begin
        if (wen1 && (waddr1 == ra)) begin
          rd = wdata1;
          rb = 1'b0;
        end else if (wen0 && (waddr0 == ra)) begin
          rd = wdata0;
          rb = 1'b0;
        end
      end
    end
`else
    assign rd = rf_q[ra];
    assign rb = busy_q[ra];
`endif

    assign rdata[k*DATA_WIDTH +: DATA_WIDTH] = rd;
    assign rbusy[k]                          = rb;
  end

endmodule

// File: tb/tb_ysyx_24100006_gpr_sb.sv
// Self-checking bench for ysyx_24100006_gpr_sb: directed scenarios plus random traffic
// compared against an array-based reference model.
module tb_ysyx_24100006_gpr_sb;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int NR = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          wen0, wen1;
  logic [AW-1:0] waddr0, waddr1;
  logic [DW-1:0] wdata0, wdata1;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;
  logic [NR-1:0] rbusy;
  logic          issue_valid;
  logic [AW-1:0] issue_rd;
  logic          issue_ready;

  int checkCount = 0;
  int passCount  = 0;

  logic [DW-1:0] modelRf [16];
  logic          modelBusy [16];

  always #5 clk = ~clk;

  ysyx_24100006_gpr_sb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR)) dut (
    .clk(clk), .reset(reset),
    .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
    .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
    .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
  endtask

  // Expected read-port values come from the model state plus, when forwarding is built in, the live writes.
  task automatic checkModel(input string tag);
    for (int k = 0; k < NR; k++) begin
      logic [AW-1:0] ra;
      logic [DW-1:0] expData;
      logic          expBusy;
      ra      = raddr[k*AW +: AW];
      expData = modelRf[ra];
      expBusy = modelBusy[ra];
`ifdef YSYX_24100006_GPR_BYPASS_EN
      if (!reset && ra != 0) begin
        if (wen1 && waddr1 == ra) begin expData = wdata1; expBusy = 1'b0; end
        else if (wen0 && waddr0 == ra) begin expData = wdata0; expBusy = 1'b0; end
      end
`endif
      checkOutput($sformatf("%s_rdata%0d", tag, k), 64'(rdata[k*DW +: DW]), 64'(expData));
      checkOutput($sformatf("%s_rbusy%0d", tag, k), 64'(rbusy[k]), 64'(expBusy));
    end
    checkOutput({tag, "_ready"}, 64'(issue_ready), 64'((issue_rd == 0) || !modelBusy[issue_rd]));
  endtask

  task automatic applyStimulus(input logic rst, input logic we0, input logic [AW-1:0] wa0, input logic [DW-1:0] wd0,
                               input logic we1, input logic [AW-1:0] wa1, input logic [DW-1:0] wd1,
                               input logic iv, input logic [AW-1:0] ir,
                               input logic [AW-1:0] ra0, input logic [AW-1:0] ra1, input string tag);
    reset = rst; wen0 = we0; waddr0 = wa0; wdata0 = wd0;
    wen1 = we1; waddr1 = wa1; wdata1 = wd1;
    issue_valid = iv; issue_rd = ir; raddr = {ra1, ra0};
    #1;
    checkModel(tag);
  endtask

  // Advance one clock and apply the architectural rules to the model.
  task automatic tick();
    logic ready;
    @(posedge clk);
    ready = (issue_rd == 0) || !modelBusy[issue_rd];
    if (reset) begin
      for (int i = 0; i < 16; i++) begin modelRf[i] = '0; modelBusy[i] = 1'b0; end
    end else begin
      if (wen0 && waddr0 != 0) begin modelRf[waddr0] = wdata0; modelBusy[waddr0] = 1'b0; end
      if (wen1 && waddr1 != 0) begin modelRf[waddr1] = wdata1; modelBusy[waddr1] = 1'b0; end
      if (issue_valid && ready && issue_rd != 0) modelBusy[issue_rd] = 1'b1;
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin modelRf[i] = '0; modelBusy[i] = 1'b0; end
    reset = 1'b1; wen0 = 0; wen1 = 0; waddr0 = 0; waddr1 = 0; wdata0 = 0; wdata1 = 0;
    issue_valid = 0; issue_rd = 0; raddr = 0;
    tick();
    tick();

    // Every index reads zero, not busy, and issuable after reset.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, AW'(i), AW'(i), AW'(15 - i), "rst");
      checkOutput("rst_rdata", 64'(rdata), 64'h0);
      checkOutput("rst_rbusy", 64'(rbusy), 64'h0);
      checkOutput("rst_ready", 64'(issue_ready), 64'h1);
    end

    // Write-port collision: port 1 wins.
    applyStimulus(0, 1, 5, 32'h11111111, 1, 5, 32'h22222222, 0, 0, 0, 0, "col");
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0, "colrd");
    checkOutput("collision_x5", 64'(rdata[DW-1:0]), 64'h22222222);

    // WAW interlock on x7.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 7, 7, 0, "iss7");
    tick();
    applyStimulus(0, 1, 7, 32'hCAFEF00D, 0, 0, 0, 1, 7, 7, 0, "stall7");
    checkOutput("x7_busy", 64'(rbusy[0]), 64'h1);
    checkOutput("x7_stall_ready", 64'(issue_ready), 64'h0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 7, 7, 0, "done7");
    checkOutput("x7_busy_cleared", 64'(rbusy[0]), 64'h0);
    checkOutput("x7_data", 64'(rdata[DW-1:0]), 64'hCAFEF00D);
    checkOutput("x7_ready", 64'(issue_ready), 64'h1);

    // Stalled issue, then clear of x3 alongside a new issue of x4, then set-wins on x3.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, "iss3");
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 3, 3, 4, "stall3");
    checkOutput("x3_stall_ready", 64'(issue_ready), 64'h0);
    tick();
    applyStimulus(0, 0, 0, 0, 1, 3, 32'h33, 1, 4, 3, 4, "clr3");
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 4, "after3");
    checkOutput("busy3_busy4", 64'(rbusy), 64'h2);
    applyStimulus(0, 1, 3, 32'h3333, 0, 0, 0, 1, 3, 3, 0, "setwin");
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, "setwinrd");
    checkOutput("setwins_busy3", 64'(rbusy[0]), 64'h1);

    // Same-cycle visibility of a write to x9.
    applyStimulus(0, 1, 9, 32'h12345678, 0, 0, 0, 0, 0, 0, 0, "pre9");
    tick();
    applyStimulus(0, 1, 9, 32'hA5A5A5A5, 0, 0, 0, 0, 0, 9, 0, "wr9");
`ifdef YSYX_24100006_GPR_BYPASS_EN
    checkOutput("x9_same_cycle", 64'(rdata[DW-1:0]), 64'hA5A5A5A5);
`else
    checkOutput("x9_same_cycle", 64'(rdata[DW-1:0]), 64'h12345678);
`endif
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 0, "rd9");
    checkOutput("x9_next_cycle", 64'(rdata[DW-1:0]), 64'hA5A5A5A5);

    // x0 is immutable and never busy.
    applyStimulus(0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 1, 0, 0, 0, "x0wr");
    checkOutput("x0_ready", 64'(issue_ready), 64'h1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "x0rd");
    checkOutput("x0_data", 64'(rdata[DW-1:0]), 64'h0);
    checkOutput("x0_busy", 64'(rbusy[0]), 64'h0);

    // Reset with busy bits pending and a write in flight.
    applyStimulus(0, 1, 2, 32'h55, 0, 0, 0, 1, 2, 2, 0, "pre2");
    tick();
    applyStimulus(1, 0, 0, 0, 1, 2, 32'h77, 0, 0, 2, 3, "rst2");
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 2, 2, 3, "post2");
    checkOutput("rst_x2_data", 64'(rdata[DW-1:0]), 64'h0);
    checkOutput("rst_busy", 64'(rbusy), 64'h0);
    checkOutput("rst_x2_ready", 64'(issue_ready), 64'h1);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      applyStimulus(($urandom_range(0, 49) == 0),
                    1'($urandom), AW'($urandom), $urandom,
                    1'($urandom), AW'($urandom), $urandom,
                    1'($urandom), AW'($urandom),
                    AW'($urandom), AW'($urandom), "rnd");
      tick();
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
